// File: rtl/proc_hier_top_if.sv
// Processor bus: combinational instruction-fetch port plus the architectural
// trace outputs (register write, memory access, halt, cycle count).
interface proc_hier_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        reg_write;
    logic [2:0]  write_register;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        halt;
    logic [31:0] cycle_count;

    // The fetch port has no handshake: imem_rdata must reflect imem_addr in the same cycle.
    modport master (
        output imem_addr, pc, inst, reg_write, write_register, write_data,
               mem_read, mem_write, mem_address, mem_data_in, mem_data_out,
               halt, cycle_count,
        input  imem_rdata
    );
    modport slave (
        input  imem_addr, pc, inst, reg_write, write_register, write_data,
               mem_read, mem_write, mem_address, mem_data_in, mem_data_out,
               halt, cycle_count,
        output imem_rdata
    );
endinterface

// File: rtl/proc_hier_top.sv
// Five-stage in-order 16-bit pipeline (IF ID EX MEM WB) with interlocks instead of
// forwarding, not-taken branch prediction resolved in EX, and a sticky HALT.
module proc_hier_top #(
    parameter int DMEM_AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    proc_hier_if.master bus
);
    typedef enum logic [4:0] {
        OP_HALT = 5'b00000, OP_NOP  = 5'b00001, OP_ADDI = 5'b01000, OP_ALU = 5'b11011,
        OP_LBI  = 5'b11000, OP_LD   = 5'b10001, OP_ST   = 5'b10000, OP_BEQZ = 5'b01100,
        OP_J    = 5'b00100
    } op_e;

    logic [15:0] pc_q, pc_d;
    logic        ifid_valid_q;
    logic [15:0] ifid_inst_q, ifid_pc2_q;
    logic        idex_valid_q, idex_we_q;
    logic [4:0]  idex_op_q;
    logic [1:0]  idex_funct_q;
    logic [2:0]  idex_wreg_q;
    logic [15:0] idex_a_q, idex_b_q, idex_imm_q, idex_pc2_q;
    logic        exmem_valid_q, exmem_we_q, exmem_ld_q, exmem_st_q;
    logic [2:0]  exmem_wreg_q;
    logic [15:0] exmem_res_q, exmem_sd_q;
    logic        memwb_we_q;
    logic [2:0]  memwb_wreg_q;
    logic [15:0] memwb_wdata_q;
    logic        halt_q;
    logic [31:0] cycle_q;
    logic [15:0] rf_q [8];
    logic [15:0] dmem_q [0:(1<<DMEM_AW)-1];

    logic [4:0]  id_op;
    logic [2:0]  id_rs, id_rt, id_wreg;
    logic        id_we, id_use_rs, id_use_rt, haz_rs, haz_rt, stall;
    logic [15:0] id_imm, rd_a, rd_b;
    logic [15:0] ex_res, ex_target;
    logic        ex_taken, ex_halt;
    logic [DMEM_AW-1:0] dmem_idx;
    logic [15:0] mem_rdata, mem_result;

    assign id_op = ifid_inst_q[15:11];
    assign id_rs = ifid_inst_q[10:8];
    assign id_rt = ifid_inst_q[7:5];

    always_comb begin
        id_we     = 1'b0;
        id_wreg   = id_rt;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        id_imm    = {{11{ifid_inst_q[4]}}, ifid_inst_q[4:0]};
        case (id_op)
            OP_ADDI, OP_LD: begin id_we = 1'b1; id_use_rs = 1'b1; end
            OP_ALU:  begin id_we = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1; id_wreg = ifid_inst_q[4:2]; end
            OP_LBI:  begin id_we = 1'b1; id_wreg = id_rs; id_imm = {{8{ifid_inst_q[7]}}, ifid_inst_q[7:0]}; end
            OP_ST:   begin id_use_rs = 1'b1; id_use_rt = 1'b1; end
            OP_BEQZ: begin id_use_rs = 1'b1; id_imm = {{8{ifid_inst_q[7]}}, ifid_inst_q[7:0]}; end
            OP_J:    id_imm = {{5{ifid_inst_q[10]}}, ifid_inst_q[10:0]};
            default: ;
        endcase
    end

    // WB is covered by the register-file bypass, so only EX and MEM producers interlock.
    assign haz_rs = (idex_valid_q && idex_we_q && idex_wreg_q == id_rs) ||
                    (exmem_valid_q && exmem_we_q && exmem_wreg_q == id_rs);
    assign haz_rt = (idex_valid_q && idex_we_q && idex_wreg_q == id_rt) ||
                    (exmem_valid_q && exmem_we_q && exmem_wreg_q == id_rt);
    assign stall  = ifid_valid_q && ((id_use_rs && haz_rs) || (id_use_rt && haz_rt));

    assign rd_a = (memwb_we_q && memwb_wreg_q == id_rs) ? memwb_wdata_q : rf_q[id_rs];
    assign rd_b = (memwb_we_q && memwb_wreg_q == id_rt) ? memwb_wdata_q : rf_q[id_rt];

    always_comb begin
        ex_res = '0;
        case (idex_op_q)
            OP_ADDI, OP_LD, OP_ST: ex_res = idex_a_q + idex_imm_q;
            OP_LBI: ex_res = idex_imm_q;
            OP_ALU: begin
                case (idex_funct_q)
                    2'b00:   ex_res = idex_a_q + idex_b_q;
                    2'b01:   ex_res = idex_b_q - idex_a_q;
                    2'b10:   ex_res = idex_a_q ^ idex_b_q;
                    default: ex_res = idex_a_q & ~idex_b_q;
                endcase
            end
            default: ;
        endcase
    end

    assign ex_taken  = idex_valid_q && ((idex_op_q == OP_BEQZ && idex_a_q == 16'h0000) || idex_op_q == OP_J);
    assign ex_target = idex_pc2_q + idex_imm_q;
    assign ex_halt   = idex_valid_q && idex_op_q == OP_HALT;
    // A taken branch overrides a stall: the stalled ID instruction is on the wrong path.
    assign pc_d      = ex_taken ? ex_target : (stall ? pc_q : pc_q + 16'd2);

    assign dmem_idx   = exmem_res_q[DMEM_AW:1];
    assign mem_rdata  = dmem_q[dmem_idx];
    assign mem_result = exmem_ld_q ? mem_rdata : exmem_res_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0; ifid_valid_q <= 1'b0; ifid_inst_q <= '0; ifid_pc2_q <= '0;
            idex_valid_q <= 1'b0; idex_we_q <= 1'b0; idex_op_q <= '0; idex_funct_q <= '0;
            idex_wreg_q <= '0; idex_a_q <= '0; idex_b_q <= '0; idex_imm_q <= '0; idex_pc2_q <= '0;
            exmem_valid_q <= 1'b0; exmem_we_q <= 1'b0; exmem_ld_q <= 1'b0; exmem_st_q <= 1'b0;
            exmem_wreg_q <= '0; exmem_res_q <= '0; exmem_sd_q <= '0;
            memwb_we_q <= 1'b0; memwb_wreg_q <= '0; memwb_wdata_q <= '0;
            halt_q <= 1'b0;
        end else if (!halt_q) begin
            halt_q        <= ex_halt;
            memwb_we_q    <= exmem_valid_q && exmem_we_q;
            memwb_wreg_q  <= exmem_wreg_q;
            memwb_wdata_q <= mem_result;
            exmem_valid_q <= idex_valid_q;
            exmem_we_q    <= idex_we_q;
            exmem_ld_q    <= idex_op_q == OP_LD;
            exmem_st_q    <= idex_op_q == OP_ST;
            exmem_wreg_q  <= idex_wreg_q;
            exmem_res_q   <= ex_res;
            exmem_sd_q    <= idex_b_q;
            idex_valid_q  <= ifid_valid_q && !stall && !ex_taken;
            idex_we_q     <= id_we;
            idex_op_q     <= id_op;
            idex_funct_q  <= ifid_inst_q[1:0];
            idex_wreg_q   <= id_wreg;
            idex_a_q      <= rd_a;
            idex_b_q      <= rd_b;
            idex_imm_q    <= id_imm;
            idex_pc2_q    <= ifid_pc2_q;
            if (ex_taken) begin
                ifid_valid_q <= 1'b0;
            end else if (!stall) begin
                ifid_valid_q <= 1'b1;
                ifid_inst_q  <= bus.imem_rdata;
                ifid_pc2_q   <= pc_q + 16'd2;
            end
            pc_q <= pc_d;
        end else begin
            // Frozen after HALT: the last WB write has retired, so drop the strobe.
            memwb_we_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else if (memwb_we_q) begin
            rf_q[memwb_wreg_q] <= memwb_wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!halt_q && exmem_valid_q && exmem_st_q) dmem_q[dmem_idx] <= exmem_sd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_q + 32'd1;
    end

    assign bus.imem_addr      = pc_q;
    assign bus.pc             = ifid_pc2_q;
    assign bus.inst           = rst ? 16'h0000 : bus.imem_rdata;
    assign bus.reg_write      = memwb_we_q;
    assign bus.write_register = memwb_wreg_q;
    assign bus.write_data     = memwb_wdata_q;
    assign bus.mem_read       = exmem_valid_q && exmem_ld_q;
    assign bus.mem_write      = exmem_valid_q && exmem_st_q;
    assign bus.mem_address    = exmem_res_q;
    assign bus.mem_data_in    = exmem_sd_q;
    assign bus.mem_data_out   = (exmem_valid_q && exmem_ld_q) ? mem_rdata : 16'h0000;
    assign bus.halt           = halt_q;
    assign bus.cycle_count    = cycle_q;
endmodule

// File: tb/tb_proc_hier_top.sv
// Bench for proc_hier_top: small programs in a bench-side instruction memory, with
// register-write and memory-access events checked against expected queues.
module tb_proc_hier_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_hier_if bus ();
    logic [15:0] imem [0:127];
    assign bus.imem_rdata = imem[bus.imem_addr[7:1]];

    proc_hier_top #(.DMEM_AW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [18:0] exp_q[$];    // {reg, data}
    logic [32:0] exp_m_q[$];  // {is_write, address, data}
    int wr_cyc[$];            // cycle_count of each observed register write
    int halt_cc;
    logic [15:0] halt_addr;

    localparam logic [15:0] I_NOP  = 16'h0800;
    localparam logic [15:0] I_HALT = 16'h0000;

    function automatic logic [15:0] e_lbi(input int r, input int imm);
        return {5'b11000, 3'(r), 8'(imm)};
    endfunction
    function automatic logic [15:0] e_ri(input logic [4:0] op, input int rs, input int rd, input int imm);
        return {op, 3'(rs), 3'(rd), 5'(imm)};
    endfunction
    function automatic logic [15:0] e_alu(input int rs, input int rt, input int rd, input int f);
        return {5'b11011, 3'(rs), 3'(rt), 3'(rd), 2'(f)};
    endfunction
    function automatic logic [15:0] e_beqz(input int rs, input int off);
        return {5'b01100, 3'(rs), 8'(off)};
    endfunction
    function automatic logic [15:0] e_j(input int off);
        return {5'b00100, 11'(off)};
    endfunction

    function automatic void push_w(input int r, input logic [15:0] d);
        exp_q.push_back({3'(r), d});
    endfunction
    function automatic void push_m(input logic w, input logic [15:0] a, input logic [15:0] d);
        exp_m_q.push_back({w, a, d});
    endfunction

    always @(negedge clk) begin : monitor
        logic [18:0] e;
        logic [32:0] m;
        logic [32:0] got_m;
        if (!rst && bus.reg_write) begin
            total++;
            wr_cyc.push_back(int'(bus.cycle_count));
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL reg_write_extra: got r%0d=%h at cycle %0d, required no write",
                         bus.write_register, bus.write_data, bus.cycle_count);
            end else begin
                e = exp_q.pop_front();
                if ({bus.write_register, bus.write_data} !== e) begin
                    bad++;
                    $display("FAIL reg_write_value: got r%0d=%h, required r%0d=%h",
                             bus.write_register, bus.write_data, e[18:16], e[15:0]);
                end
            end
        end
        if (!rst && (bus.mem_read || bus.mem_write)) begin
            total++;
            got_m = {bus.mem_write, bus.mem_address, bus.mem_write ? bus.mem_data_in : bus.mem_data_out};
            if (exp_m_q.size() == 0) begin
                bad++;
                $display("FAIL mem_access_extra: got w=%b addr=%h data=%h, required none",
                         got_m[32], got_m[31:16], got_m[15:0]);
            end else begin
                m = exp_m_q.pop_front();
                if (got_m !== m || (bus.mem_read && bus.mem_write)) begin
                    bad++;
                    $display("FAIL mem_access_value: got w=%b addr=%h data=%h, required w=%b addr=%h data=%h",
                             got_m[32], got_m[31:16], got_m[15:0], m[32], m[31:16], m[15:0]);
                end
            end
        end
    end

    task automatic clear_all();
        rst = 1'b1;
        exp_q.delete();
        exp_m_q.delete();
        wr_cyc.delete();
        for (int i = 0; i < 128; i++) imem[i] = I_NOP;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        int n = 0;
        while (bus.halt !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        halt_cc   = int'(bus.cycle_count);
        halt_addr = bus.imem_addr;
        total++;
        if (bus.halt !== 1'b1) begin
            bad++;
            $display("FAIL halt_timeout: halt=%b after %0d cycles, required 1", bus.halt, n);
        end
        repeat (8) @(negedge clk);
        total++;
        if (exp_q.size() != 0 || exp_m_q.size() != 0) begin
            bad++;
            $display("FAIL events_missing: %0d reg and %0d mem events outstanding, required 0",
                     exp_q.size(), exp_m_q.size());
        end
    endtask

    task automatic load_alu_prog();
        imem[0] = e_lbi(1, 5);
        imem[1] = e_lbi(2, -3);
        imem[2] = e_lbi(7, 8'h3C);
        imem[4] = e_alu(1, 2, 3, 0);
        imem[5] = e_alu(1, 7, 4, 1);
        imem[6] = e_alu(1, 7, 5, 2);
        imem[7] = e_alu(7, 1, 6, 3);
        imem[8] = e_ri(5'b01000, 2, 0, -1);
        imem[9] = I_HALT;
        push_w(1, 16'h0005);
        push_w(2, 16'hFFFD);
        push_w(7, 16'h003C);
        push_w(3, 16'h0005 + 16'hFFFD);
        push_w(4, 16'h003C - 16'h0005);
        push_w(5, 16'h0005 ^ 16'h003C);
        push_w(6, 16'h003C & ~16'h0005);
        push_w(0, 16'hFFFD + 16'hFFFF);
    endtask

    task automatic test_reset();
        clear_all();
        #3;
        total++;
        if (bus.cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_cycle_count: got %0d, required 0", bus.cycle_count);
        end
        total++;
        if ({bus.reg_write, bus.mem_read, bus.mem_write, bus.halt} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_strobes: got %b, required 0000",
                     {bus.reg_write, bus.mem_read, bus.mem_write, bus.halt});
        end
        total++;
        if ({bus.imem_addr, bus.pc, bus.inst, bus.write_register, bus.write_data, bus.mem_address,
             bus.mem_data_in, bus.mem_data_out} !== '0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h pc=%h inst=%h wd=%h ma=%h, required all 0",
                     bus.imem_addr, bus.pc, bus.inst, bus.write_data, bus.mem_address);
        end
    endtask

    task automatic test_alu();
        clear_all();
        load_alu_prog();
        release_rst();
        run_to_halt(200);
        total++;
        if (wr_cyc.size() < 1 || wr_cyc[0] != 4) begin
            bad++;
            $display("FAIL first_write_latency: got cycle %0d, required 4", wr_cyc.size() > 0 ? wr_cyc[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        imem[0] = e_lbi(1, 7);
        imem[1] = e_ri(5'b01000, 1, 2, 1);
        imem[2] = e_alu(2, 2, 3, 0);
        imem[3] = e_lbi(4, 1);
        imem[5] = e_ri(5'b01000, 4, 5, 2);
        imem[6] = I_HALT;
        push_w(1, 16'h0007);
        push_w(2, 16'h0008);
        push_w(3, 16'h0010);
        push_w(4, 16'h0001);
        push_w(5, 16'h0003);
        release_rst();
        run_to_halt(200);
        total++;
        if (wr_cyc.size() < 5 || wr_cyc[1] - wr_cyc[0] != 3 || wr_cyc[2] - wr_cyc[1] != 3) begin
            bad++;
            $display("FAIL dep_distance1_gap: got %0d writes, required gaps of 3 cycles", wr_cyc.size());
        end
        total++;
        if (wr_cyc.size() < 5 || wr_cyc[3] - wr_cyc[2] != 1 || wr_cyc[4] - wr_cyc[3] != 3) begin
            bad++;
            $display("FAIL dep_distance2_gap: got %0d writes, required gaps 1 then 3", wr_cyc.size());
        end
    endtask

    task automatic test_mem();
        logic [15:0] r;
        clear_all();
        r = 16'h0012;
        imem[0] = e_lbi(1, 8'h12);
        push_w(1, r);
        for (int i = 1; i <= 8; i++) begin
            imem[i] = e_alu(1, 1, 1, 0);
            r = r + r;
            push_w(1, r);
        end
        imem[9]  = e_lbi(2, 8'h34);
        imem[10] = e_alu(1, 2, 1, 0);
        imem[11] = e_ri(5'b10000, 0, 1, 4);
        imem[12] = e_ri(5'b10001, 0, 4, 4);
        imem[13] = e_ri(5'b10001, 0, 5, 5);
        imem[14] = I_HALT;
        push_w(2, 16'h0034);
        push_w(1, r + 16'h0034);
        push_w(4, 16'h1234);
        push_w(5, 16'h1234);
        push_m(1'b1, 16'h0004, 16'h1234);
        push_m(1'b0, 16'h0004, 16'h1234);
        push_m(1'b0, 16'h0005, 16'h1234);
        release_rst();
        run_to_halt(300);
    endtask

    task automatic test_branch();
        clear_all();
        imem[0]  = e_beqz(0, 4);
        imem[1]  = e_lbi(1, 1);
        imem[2]  = e_lbi(2, 2);
        imem[3]  = e_lbi(3, 3);
        imem[4]  = e_lbi(6, 1);
        imem[7]  = e_beqz(6, 4);
        imem[8]  = e_lbi(4, 4);
        imem[9]  = e_j(2);
        imem[10] = I_HALT;
        imem[11] = e_lbi(2, 8'h22);
        imem[12] = I_HALT;
        push_w(3, 16'h0003);
        push_w(6, 16'h0001);
        push_w(4, 16'h0004);
        push_w(2, 16'h0022);
        release_rst();
        run_to_halt(200);
        total++;
        if (wr_cyc.size() < 1 || wr_cyc[0] != 7) begin
            bad++;
            $display("FAIL taken_branch_cost: got target write at cycle %0d, required 7",
                     wr_cyc.size() > 0 ? wr_cyc[0] : -1);
        end
        total++;
        if (wr_cyc.size() < 3 || wr_cyc[2] - wr_cyc[1] != 4) begin
            bad++;
            $display("FAIL untaken_no_bubble: got %0d writes, required fall-through 4 cycles after r6", wr_cyc.size());
        end
        total++;
        if (halt_cc != 16) begin
            bad++;
            $display("FAIL wrong_path_halt: got halt at cycle %0d, required 16", halt_cc);
        end
    endtask

    task automatic test_halt();
        clear_all();
        imem[0] = e_lbi(1, 9);
        imem[1] = I_HALT;
        imem[2] = e_lbi(2, 2);
        imem[3] = e_lbi(3, 3);
        push_w(1, 16'h0009);
        release_rst();
        #1;
        total++;
        if (bus.cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL cycle_count_first: got %0d, required 0", bus.cycle_count);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.cycle_count !== 32'(i)) begin
                bad++;
                $display("FAIL cycle_count_step: got %0d, required %0d", bus.cycle_count, i);
            end
        end
        run_to_halt(100);
        total++;
        if (halt_cc != 4) begin
            bad++;
            $display("FAIL halt_cycle: got %0d, required 4", halt_cc);
        end
        total++;
        if (bus.cycle_count !== 32'(halt_cc + 8) || bus.imem_addr !== halt_addr || bus.halt !== 1'b1) begin
            bad++;
            $display("FAIL halt_freeze: got cc=%0d addr=%h halt=%b, required cc=%0d addr=%h halt=1",
                     bus.cycle_count, bus.imem_addr, bus.halt, halt_cc + 8, halt_addr);
        end
    endtask

    task automatic test_reset_mid();
        clear_all();
        load_alu_prog();
        release_rst();
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.reg_write, bus.halt, bus.cycle_count, bus.imem_addr, bus.pc} !== '0) begin
            bad++;
            $display("FAIL mid_reset_abort: got we=%b cc=%0d addr=%h pc=%h, required all 0",
                     bus.reg_write, bus.cycle_count, bus.imem_addr, bus.pc);
        end
        exp_q.delete();
        wr_cyc.delete();
        load_alu_prog();
        release_rst();
        run_to_halt(200);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_mem();
        test_branch();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
